icache_assoc: RTL

- Parametrised set-associative instruction cache; successor to the 16-entry, one-word-per-line direct-mapped ICache.
- Sits between the fetch stage (PC in, instruction out, stall out) and the instruction memory port.
- Adds configurable ways, sets and line length.
- Adds a multi-beat burst refill over a req/ack handshake, per-set round-robin replacement, and a whole-cache flush.

---
 rtl/icache_assoc.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with burst refill, round-robin
// replacement per set and whole-cache flush.
module icache_assoc #(
    parameter int WAYS  = 2,
    parameter int SETS  = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Addr,
    input  logic        ReqValid,
    input  logic        Flush,
    output logic [31:0] Inst,
    output logic        InstValid,
    output logic        IStall,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic [31:0] MemData,
    input  logic        MemAck
);

    localparam int WB  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int OFF = $clog2(WORDS) + 2;
    localparam int IDX = $clog2(SETS);
    localparam int TW  = 32 - OFF - IDX;
    localparam int VW  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RESP
    } state_t;

    state_t state;

    logic [31:0]     data_mem [SETS][WAYS][WORDS];
    logic [TW-1:0]   tag_mem  [SETS][WAYS];
    logic [WAYS-1:0] valid    [SETS];
    logic [VW-1:0]   vptr     [SETS];

    logic [TW-1:0]  req_tag;
    logic [IDX-1:0] req_idx;
    logic [WB-1:0]  req_word;

    logic           hit;
    logic [VW-1:0]  hit_way;
    logic [31:0]    hit_data;
    logic [VW-1:0]  vic_way;
    logic           vic_free;
    logic [VW-1:0]  ptr_next;
    logic           clear_all;
    logic           last_beat;

    logic [TW-1:0]  fill_tag;
    logic [IDX-1:0] fill_idx;
    logic [WB-1:0]  fill_word;
    logic [VW-1:0]  fill_way;
    logic           fill_by_ptr;
    logic [WB-1:0]  beat;
    logic [31:0]    fill_inst;
    logic           flush_pend;

    logic unused_addr;
    assign unused_addr = ^Addr[1:0];

    assign req_tag = Addr[31:OFF+IDX];
    assign req_idx = Addr[OFF+IDX-1:OFF];

    generate
        if (WORDS > 1) begin : g_word
            assign req_word = Addr[OFF-1:2];
        end else begin : g_one_word
            assign req_word = 1'b0;
        end
    endgenerate

    // Tag compare across all ways of the addressed set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = VW'(w);
            end
        end
    end

    assign hit_data = data_mem[req_idx][hit_way][req_word];

    // Victim: lowest invalid way, else the set's round-robin pointer;
    // a same-cycle flush empties the set so way 0 is taken
    always_comb begin
        vic_way  = vptr[req_idx];
        vic_free = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[req_idx][w]) begin
                vic_way  = VW'(w);
                vic_free = 1'b1;
            end
        end
        if (Flush) begin
            vic_way  = '0;
            vic_free = 1'b1;
        end
    end

    assign ptr_next = (vptr[fill_idx] == VW'(WAYS - 1)) ? '0
                    : vptr[fill_idx] + 1'b1;

    assign last_beat = (beat == WB'(WORDS - 1));

    assign clear_all = (state == IDLE && Flush)
                    || (state == RESP && (Flush || flush_pend));

    // Line storage: refill beats and the tag land in the victim way
    always_ff @(posedge clk) begin
        if (state == FILL && MemAck) begin
            data_mem[fill_idx][fill_way][beat] <= MemData;
            if (last_beat) begin
                tag_mem[fill_idx][fill_way] <= fill_tag;
            end
        end
    end

    // Control FSM, valid bits, victim pointers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            Inst        <= '0;
            InstValid   <= 1'b0;
            IStall      <= 1'b0;
            MemReq      <= 1'b0;
            MemAddr     <= '0;
            fill_tag    <= '0;
            fill_idx    <= '0;
            fill_word   <= '0;
            fill_way    <= '0;
            fill_by_ptr <= 1'b0;
            beat        <= '0;
            fill_inst   <= '0;
            flush_pend  <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                vptr[s]  <= '0;
            end
        end else begin
            InstValid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ReqValid) begin
                        if (hit && !Flush) begin
                            Inst      <= hit_data;
                            InstValid <= 1'b1;
                        end else begin
                            IStall      <= 1'b1;
                            MemReq      <= 1'b1;
                            MemAddr     <= {Addr[31:OFF], {OFF{1'b0}}};
                            beat        <= '0;
                            fill_tag    <= req_tag;
                            fill_idx    <= req_idx;
                            fill_word   <= req_word;
                            fill_way    <= vic_way;
                            fill_by_ptr <= !vic_free;
                            valid[req_idx][vic_way] <= 1'b0;
                            state       <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (Flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (MemAck) begin
                        beat    <= beat + 1'b1;
                        MemAddr <= MemAddr + 32'd4;
                        if (beat == fill_word) begin
                            fill_inst <= MemData;
                        end
                        if (last_beat) begin
                            valid[fill_idx][fill_way] <= 1'b1;
                            if (fill_by_ptr) begin
                                vptr[fill_idx] <= ptr_next;
                            end
                            MemReq <= 1'b0;
                            state  <= RESP;
                        end
                    end
                end
                RESP: begin
                    Inst       <= fill_inst;
                    InstValid  <= 1'b1;
                    IStall     <= 1'b0;
                    flush_pend <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (clear_all) begin
                for (int s = 0; s < SETS; s++) begin
                    valid[s] <= '0;
                    vptr[s]  <= '0;
                end
            end
        end
    end

endmodule
